keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: cycles a column is driven before its rows are sampled; legal range 3..255.
REQ-002 The block SHALL have parameter DEBOUNCE_FRAMES, default 3: number of consecutive identical scan frames needed before key updates; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1: the single system clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port row, input, 4: raw asynchronous keypad row lines, active-low (pulled up; 0 = key closed in driven column).
REQ-006 The block SHALL have port col, output, 4: column drive, active-low, exactly one bit low at all times.
REQ-007 The block SHALL have port key, output, 16: debounced key vector, bit 4*r+c for row r and column c; either all-zero or one-hot.
REQ-008 The block SHALL have port key_new, output, 1: one-cycle pulse when key changes to a nonzero value.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-010 The FSM SHALL have states DRIVE, SAMPLE and EVAL, plus a 2-bit column index and a settle counter.
REQ-011 In DRIVE, col SHALL drive the current column low for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-012 SAMPLE SHALL last 1 cycle and capture ~row_sync into frame bits {12+c, 8+c, 4+c, c}; columns 0..2 then advance the column index and return to DRIVE, and column 3 goes to EVAL.
REQ-013 EVAL SHALL last 1 cycle, keep col at column 3, then go to DRIVE with column 0; frame length is 4*(SETTLE_CYCLES+1)+1 cycles (21 at defaults).
REQ-014 In EVAL, if frame equals prev_frame then stable_cnt SHALL increment, saturating at DEBOUNCE_FRAMES; otherwise it SHALL be set to 1; prev_frame is then loaded with frame.
REQ-015 In EVAL, if the updated stable_cnt equals DEBOUNCE_FRAMES and frame is zero or one-hot, key SHALL load frame on the next edge.
REQ-016 A frame with two or more bits set SHALL be treated as invalid: key holds its last value and the debounce count still tracks it.
REQ-017 key_new SHALL be 1 for exactly the cycle key first shows a new nonzero value; it SHALL NOT pulse on release to zero or on a reload of the same value.
REQ-018 A held key SHALL produce exactly one key_new pulse per press, regardless of hold duration.
REQ-019 Frame bits SHALL clear at the start of each frame (column 0 DRIVE) so the frame reflects only the current scan.

Reset
REQ-020 On reset, state SHALL become DRIVE at column 0 with the settle counter at 0, so col = 4'b1110 on the following cycle.
REQ-021 On reset, key, frame and prev_frame SHALL go to 16'h0000, and stable_cnt and key_new SHALL go to 0.
REQ-022 On reset, the synchronizer flops SHALL go to 4'b1111 (released).
REQ-023 Reset asserted mid-frame SHALL abandon the partial frame with no key update.

Structure
REQ-024 The shared package keypad_pkg SHALL hold the scan-state enum (DRIVE, SAMPLE, EVAL) and the constants NUM_ROWS = 4 and NUM_COLS = 4.
REQ-025 One sub-module, sync_2ff (4-bit, synchronous reset to all-ones), SHALL implement the synchronizer.
REQ-026 The key output format SHALL be directly consumable by the existing key-to-digit decoder FSM, with no glue logic.

Verification
REQ-027 With defaults and row = 4'b1101 driven only while col = 4'b1011 from reset release: key SHALL become 16'h0040 and key_new SHALL pulse once after the 3rd EVAL (cycle 63), and no further pulses SHALL occur while the key is held.
REQ-028 With the key held, then row = 4'b1111 continuously: key SHALL return to 16'h0000 after 3 released frames, with no key_new pulse.
REQ-029 Bounce: press toggled every 7 cycles for 2 frames, then held: key SHALL stay 16'h0000 until 3 clean frames are seen, then show 16'h0040 with one key_new pulse.
REQ-030 Two keys (r0c0 and r1c1 = 16'h0021) held for 5 frames after 16'h0040 was stable: key SHALL stay 16'h0040 with no key_new.
REQ-031 Reset asserted for 1 cycle mid-frame while 16'h0040 is stable: the next cycle SHALL show col = 4'b1110 and key = 16'h0000, and the block SHALL re-acquire 16'h0040 63 cycles after reset release.
REQ-032 The col output SHALL be checked every cycle by assertion to have exactly one zero bit and to follow the sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad geometry (key bit index = NUM_COLS*row + col)
//   scan_state_t        : scan FSM states (DRIVE, SAMPLE, EVAL)
//   is_zero_or_onehot   : true when a key vector names at most one key
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SAMPLE = 2'd1,
        EVAL   = 2'd2
    } scan_state_t;

    // v & (v-1) clears the lowest set bit; the result is zero only when
    // v had no bits or exactly one bit set.
    function automatic logic is_zero_or_onehot(input logic [NUM_KEYS-1:0] v);
        return (v & (v - NUM_KEYS'(1))) == '0;
    endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for the asynchronous keypad row lines.
//   clk   : system clock
//   reset : synchronous active-high reset; both stages go to all-ones
//           (row lines idle high, i.e. no key closed)
//   d     : asynchronous input
//   q     : synchronized output, two cycles behind d
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// Column-scanning 4x4 keypad controller with frame-level debounce.
// Each frame drives columns 0..3 low in turn, samples the rows of each
// column after a settle time, then evaluates the whole 16-bit frame.
// A frame is accepted into key after DEBOUNCE_FRAMES identical frames,
// provided it names no more than one key.
//   clk     : system clock, rising edge
//   reset   : synchronous active-high reset
//   row     : raw row lines, active-low (0 = key closed in driven column)
//   col     : column drive, active-low, exactly one bit low
//   key     : debounced key vector, bit 4*r+c, all-zero or one-hot
//   key_new : one-cycle pulse when key takes a new nonzero value
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [NUM_KEYS-1:0] key,
    output logic                key_new
);

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEBOUNCE_MAX = 4'(DEBOUNCE_FRAMES);
    localparam logic [1:0] LAST_COL     = 2'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_sync;

    scan_state_t         state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [7:0]          settle_q, settle_d;
    logic [NUM_KEYS-1:0] frame_q, frame_d;
    logic [NUM_KEYS-1:0] prev_frame_q, prev_frame_d;
    logic [3:0]          stable_cnt_q, stable_cnt_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic                key_new_q, key_new_d;

    // Frame with the currently driven column replaced by the sampled rows.
    logic [NUM_KEYS-1:0] frame_captured;

    sync_2ff #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_sync)
    );

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
            assign col[gi] = (col_idx_q != 2'(gi));
        end

        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
                assign frame_captured[gi*NUM_COLS + gj] =
                    (col_idx_q == 2'(gj)) ? ~row_sync[gi] : frame_q[gi*NUM_COLS + gj];
            end
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        settle_d     = settle_q;
        frame_d      = frame_q;
        prev_frame_d = prev_frame_q;
        stable_cnt_d = stable_cnt_q;
        key_d        = key_q;
        key_new_d    = 1'b0;

        unique case (state_q)
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = 8'd0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            SAMPLE: begin
                frame_d = frame_captured;
                if (col_idx_q == LAST_COL) begin
                    state_d = EVAL;
                end else begin
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = DRIVE;
                end
            end

            EVAL: begin
                if (frame_q == prev_frame_q) begin
                    stable_cnt_d = (stable_cnt_q >= DEBOUNCE_MAX) ? DEBOUNCE_MAX
                                                                  : stable_cnt_q + 4'd1;
                end else begin
                    stable_cnt_d = 4'd1;
                end
                prev_frame_d = frame_q;

                // Multi-key frames still feed the debounce count above but
                // never reach key, so key keeps its last valid value.
                if (stable_cnt_d == DEBOUNCE_MAX && is_zero_or_onehot(frame_q)) begin
                    key_d     = frame_q;
                    key_new_d = (frame_q != '0) && (frame_q != key_q);
                end

                // Start the next frame from a clean slate at column 0.
                frame_d   = '0;
                col_idx_d = 2'd0;
                state_d   = DRIVE;
            end

            default: begin
                state_d   = DRIVE;
                col_idx_d = 2'd0;
                settle_d  = 8'd0;
                frame_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DRIVE;
            col_idx_q    <= 2'd0;
            settle_q     <= 8'd0;
            frame_q      <= '0;
            prev_frame_q <= '0;
            stable_cnt_q <= 4'd0;
            key_q        <= '0;
            key_new_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            settle_q     <= settle_d;
            frame_q      <= frame_d;
            prev_frame_q <= prev_frame_d;
            stable_cnt_q <= stable_cnt_d;
            key_q        <= key_d;
            key_new_q    <= key_new_d;
        end
    end

    assign key     = key_q;
    assign key_new = key_new_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Self-checking bench for keypad_scan: a keypad model turns a "pressed"
// key vector into row levels for the driven column; a frame-level reference
// model predicts col, key and key_new every cycle. Directed scenarios cover
// first press, release, bounce, two-key rejection and mid-frame reset,
// followed by randomized press/hold/bounce/reset sequences.
module tb_keypad_scan;

    localparam int S     = 4;
    localparam int D     = 3;
    localparam int FRAME = 4 * (S + 1) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key;
    logic        key_new;

    logic [15:0] pressed;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    // Reference model state
    int          m_pos;
    logic [15:0] m_frame, m_prev, m_key;
    int          m_cnt;
    logic        m_new;
    logic [15:0] ph [3];
    bit          model_valid = 1'b0;

    keypad_scan #(
        .SETTLE_CYCLES   (S),
        .DEBOUNCE_FRAMES (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .row     (row),
        .col     (col),
        .key     (key),
        .key_new (key_new)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col[c] == 1'b0 && pressed[r*4 + c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] col_for_pos(input int pos);
        int idx;
        logic [3:0] one;
        idx = pos / (S + 1);
        if (idx > 3) idx = 3;
        one = 4'b0001 << idx;
        return ~one;
    endfunction

    // Monitor + reference model, evaluated mid-cycle.
    initial begin
        logic [3:0] prev_col;
        bit         after_reset;
        int         c;
        logic [15:0] f;
        after_reset = 1'b1;
        prev_col    = 4'hF;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("col", 32'(col), 32'(col_for_pos(m_pos)));
                check("col_onecold", 32'($countones(~col)), 32'd1);
                if (!after_reset && col !== prev_col)
                    check("col_seq", 32'(col), 32'({prev_col[2:0], prev_col[3]}));
                check("key", 32'(key), 32'(m_key));
                check("key_new", 32'(key_new), 32'(m_new));
                if (key_new === 1'b1) pulse_cnt++;
            end
            prev_col = col;
            // Rows seen by the scanner lag the keypad by the synchronizer depth.
            ph[2] = ph[1];
            ph[1] = ph[0];
            ph[0] = pressed;
            if (reset === 1'b1) begin
                m_pos = 0; m_frame = '0; m_prev = '0; m_key = '0;
                m_cnt = 0; m_new = 1'b0;
                ph[0] = '0; ph[1] = '0; ph[2] = '0;
                model_valid = 1'b1;
                after_reset = 1'b1;
            end else if (model_valid) begin
                after_reset = 1'b0;
                m_new = 1'b0;
                if ((m_pos % (S + 1)) == S && m_pos < 4 * (S + 1)) begin
                    c = m_pos / (S + 1);
                    for (int r = 0; r < 4; r++) m_frame[r*4 + c] = ph[2][r*4 + c];
                end
                if (m_pos == FRAME - 1) begin
                    f = m_frame;
                    m_cnt = (f == m_prev) ? ((m_cnt + 1 > D) ? D : m_cnt + 1) : 1;
                    m_prev = f;
                    if (m_cnt == D && $countones(f) <= 1) begin
                        m_new = (f != 16'h0) && (f != m_key);
                        m_key = f;
                    end
                    m_frame = '0;
                end
                m_pos = (m_pos + 1) % FRAME;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_pos == target) break;
            cycles(1);
        end
        check("align", 32'(m_pos), 32'(target));
    endtask

    initial begin
        int base;
        int pat, hold, bounce, nb, b0, b1;
        reset   = 1'b1;
        pressed = 16'h0000;
        ph[0] = '0; ph[1] = '0; ph[2] = '0;
        cycles(3);

        // First press held from reset release.
        reset   = 1'b0;
        pressed = 16'h0040;
        base    = pulse_cnt;
        check("rst_col", 32'(col), 32'h0000_000E);
        check("rst_key", 32'(key), 32'h0);
        check("rst_key_new", 32'(key_new), 32'h0);
        cycles(62);
        check("c62_key", 32'(key), 32'h0);
        cycles(1);
        check("c63_key", 32'(key), 32'h0040);
        check("c63_key_new", 32'(key_new), 32'h1);
        cycles(5 * FRAME);
        check("hold_pulses", 32'(pulse_cnt - base), 32'd1);
        $display("txn press    key=%h", key);

        // Release.
        base    = pulse_cnt;
        pressed = 16'h0000;
        cycles(4 * FRAME);
        check("rel_key", 32'(key), 32'h0);
        check("rel_pulses", 32'(pulse_cnt - base), 32'd0);
        $display("txn release  key=%h", key);

        // Bounce for two frames, then held.
        wait_pos(0);
        base = pulse_cnt;
        for (int i = 0; i < 2 * FRAME; i++) begin
            pressed = ((i / 7) % 2 == 0) ? 16'h0040 : 16'h0000;
            cycles(1);
        end
        pressed = 16'h0040;
        cycles(FRAME);
        check("bnc_key_early", 32'(key), 32'h0);
        cycles(3 * FRAME);
        check("bnc_key", 32'(key), 32'h0040);
        check("bnc_pulses", 32'(pulse_cnt - base), 32'd1);
        $display("txn bounce   key=%h", key);

        // Two keys held: invalid frames must not disturb key.
        base    = pulse_cnt;
        pressed = 16'h0021;
        cycles(5 * FRAME);
        check("two_key", 32'(key), 32'h0040);
        check("two_pulses", 32'(pulse_cnt - base), 32'd0);
        $display("txn twokey   key=%h", key);

        // Back to one key, then reset mid-frame.
        pressed = 16'h0040;
        cycles(4 * FRAME);
        wait_pos(7);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid_rst_col", 32'(col), 32'h0000_000E);
        check("mid_rst_key", 32'(key), 32'h0);
        cycles(62);
        check("reacq_early", 32'(key), 32'h0);
        cycles(1);
        check("reacq_key", 32'(key), 32'h0040);
        $display("txn midreset key=%h", key);

        // Randomized sequences, checked cycle by cycle by the model.
        for (int t = 0; t < 40; t++) begin
            pat = $urandom_range(0, 9);
            b0  = $urandom_range(0, 15);
            b1  = (b0 + $urandom_range(1, 15)) % 16;
            if (pat < 3)      pat = 0;
            else if (pat < 8) pat = 1 << b0;
            else              pat = (1 << b0) | (1 << b1);
            hold   = $urandom_range(1, 5);
            bounce = ($urandom_range(0, 2) == 0);
            if (bounce) begin
                nb = $urandom_range(5, 30);
                for (int i = 0; i < nb; i++) begin
                    pressed = $urandom_range(0, 1) ? 16'(pat) : 16'h0;
                    cycles(1);
                end
            end
            pressed = 16'(pat);
            cycles(hold * FRAME);
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                cycles(1);
                reset = 1'b0;
            end
            $display("txn %0d pattern=%h hold=%0d bounce=%0d key=%h",
                     t, pattern_str(pat), hold, bounce, key);
        end

        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [15:0] pattern_str(input int p);
        return 16'(p);
    endfunction

endmodule
